// File: rtl/coin_input_encoder.sv
// Coin sensor front end for the vending FSM: two-flop synchronisers,
// per-channel debounce FSMs, registered Inp arbitration and a saturating
// count of accepted coins.

// One debounce channel. It fires for one cycle when a press has been
// stable for DEBOUNCE_CYCLES+1 synchronised samples.
module coin_input_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    output logic fire,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    localparam logic [7:0] D = 8'(DEBOUNCE_CYCLES);

    state_t     state;
    logic [7:0] cnt;

    // The press is accepted on the edge where the FSM enters HELD.
    // Firing combinationally lets the arbiter register Inp on that same edge.
    assign fire = (state == DEB_PRESS) && s && (cnt >= D);
    assign busy = (state != IDLE);

    // Debounce state machine: count consecutive stable samples in each direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: if (s) begin
                    state <= DEB_PRESS;
                    cnt   <= 8'd1;
                end
                DEB_PRESS: if (!s) begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end else if (cnt < D) begin
                    cnt <= cnt + 8'd1;
                end else begin
                    state <= HELD;
                    cnt   <= 8'd0;
                end
                HELD: if (!s) begin
                    state <= DEB_RELEASE;
                    cnt   <= 8'd1;
                end
                DEB_RELEASE: if (s) begin
                    state <= HELD;
                    cnt   <= 8'd0;
                end else if (cnt < D) begin
                    cnt <= cnt + 8'd1;
                end else begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end
endmodule

module coin_input_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    output logic [1:0]       Inp,
    output logic             busy,
    output logic [CNT_W-1:0] coin_count
);
    localparam int NUM_LANES = 2;   // lane 0 = 5-unit, lane 1 = 10-unit

    logic [NUM_LANES-1:0]      raw, s, fire, lane_busy;
    logic [NUM_LANES-1:0][1:0] sync_pipe;
    logic                      pending;
    logic [1:0]                code_next;
    logic                      pend_next;

    assign raw = {coin10_raw, coin5_raw};

    // Two-flop synchroniser per raw line; bit 1 is the settled sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pipe <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++)
                sync_pipe[i] <= {sync_pipe[i][0], raw[i]};
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign s[g] = sync_pipe[g][1];
        coin_input_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk   (clk),
            .reset (reset),
            .s     (s[g]),
            .fire  (fire[g]),
            .busy  (lane_busy[g])
        );
    end

    // Arbitration: 5-unit wins a tie, the 10-unit code is deferred one cycle.
    always_comb begin
        code_next = 2'b00;
        pend_next = 1'b0;
        if (fire[0]) begin
            code_next = 2'b01;
            pend_next = fire[1];
        end else if (fire[1] || pending) begin
            code_next = 2'b10;
        end
    end

    // Register the code, the deferred flag and the saturating coin count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Inp        <= 2'b00;
            pending    <= 1'b0;
            coin_count <= '0;
        end else begin
            Inp     <= code_next;
            pending <= pend_next;
            if (code_next != 2'b00 && coin_count != '1)
                coin_count <= coin_count + 1'b1;
        end
    end

    assign busy = (|lane_busy) | pending;
endmodule

// File: tb/tb_coin_input_encoder.sv
module tb_coin_input_encoder;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset, coin5_raw, coin10_raw;
    logic [1:0] inp, inp_s;
    logic       busy, busy_s;
    logic [7:0] cnt;
    logic [1:0] cnt_s;

    always #5 clk = ~clk;

    coin_input_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .Inp(inp), .busy(busy), .coin_count(cnt));

    coin_input_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .Inp(inp_s), .busy(busy_s), .coin_count(cnt_s));

    int checks = 0;
    int errors = 0;

    // Reference model: each channel has an accepted level and a run length of
    // synchronised samples disagreeing with it; D+1 in a row flips the level.
    bit       ms1[2], ms2[2], lvl[2];
    int       run[2];
    bit [1:0] m_inp;
    bit       m_pend;
    int       total;
    int       pulses5, pulses10;

    function automatic int sat(int t, int m);
        return (t > m) ? m : t;
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            ms1[c] = 0; ms2[c] = 0; lvl[c] = 0; run[c] = 0;
        end
        m_inp = 0; m_pend = 0; total = 0;
    endfunction

    function automatic void m_step(bit r5, bit r10);
        bit fire[2];
        for (int c = 0; c < 2; c++) begin
            fire[c] = 0;
            if (ms2[c] != lvl[c]) begin
                run[c]++;
                if (run[c] == D + 1) begin
                    lvl[c]  = ms2[c];
                    run[c]  = 0;
                    fire[c] = lvl[c];
                end
            end else begin
                run[c] = 0;
            end
        end
        if (fire[0]) begin
            m_inp = 2'b01; m_pend = fire[1];
        end else if (fire[1] || m_pend) begin
            m_inp = 2'b10; m_pend = 0;
        end else begin
            m_inp = 2'b00;
        end
        if (m_inp != 0) total++;
        ms2[0] = ms1[0]; ms2[1] = ms1[1];
        ms1[0] = r5;     ms1[1] = r10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit mb;
        mb = lvl[0] | lvl[1] | (run[0] != 0) | (run[1] != 0) | m_pend;
        chk("inp",     32'(inp),    32'(m_inp));
        chk("busy",    32'(busy),   32'(mb));
        chk("count",   32'(cnt),    32'(sat(total, 255)));
        chk("inp_s",   32'(inp_s),  32'(m_inp));
        chk("busy_s",  32'(busy_s), 32'(mb));
        chk("count_s", 32'(cnt_s),  32'(sat(total, 3)));
    endtask

    // One clock: check state after the last edge, drive, advance model.
    task automatic cycle(input bit r5, input bit r10);
        @(negedge clk);
        check_all();
        if (inp == 2'b01) pulses5++;
        if (inp == 2'b10) pulses10++;
        coin5_raw  = r5;
        coin10_raw = r10;
        m_step(r5, r10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_all();
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;
        m_step(coin5_raw, coin10_raw);
    endtask

    initial begin
        int  h5, h10, n;
        bit  l5, l10, seen;
        reset = 1'b1; coin5_raw = 0; coin10_raw = 0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_inp", 32'(inp), 32'd0);
        reset = 1'b0;
        m_step(0, 0);

        // Clean 5-unit press held 20 cycles: one pulse, at the 7th edge.
        pulses5 = 0;
        cycle(1, 0);
        for (int i = 0; i < 7; i++) cycle(1, 0);
        chk("t1_latency", 32'(inp), 32'd1);
        for (int i = 0; i < 12; i++) cycle(1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0);
        chk("t1_pulses", 32'(pulses5), 32'd1);

        // Glitch on coin10 for 3 cycles: no code, no count change.
        pulses10 = 0;
        for (int i = 0; i < 3; i++) cycle(0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0);
        chk("t2_pulses", 32'(pulses10), 32'd0);
        chk("t2_count",  32'(cnt), 32'd1);
        chk("t2_busy",   32'(busy), 32'd0);

        // Simultaneous press: 01 then 10 then 00.
        pulses5 = 0; pulses10 = 0;
        for (int i = 0; i < 14; i++) cycle(1, 1);
        for (int i = 0; i < 12; i++) cycle(0, 0);
        chk("t3_p5",  32'(pulses5), 32'd1);
        chk("t3_p10", 32'(pulses10), 32'd1);
        chk("t3_count", 32'(cnt), 32'd3);

        // Bouncy release then re-press: two 01 pulses total.
        pulses5 = 0;
        for (int i = 0; i < 10; i++) cycle(1, 0);
        for (int b = 0; b < 3; b++) begin
            cycle(0, 0); cycle(0, 0); cycle(1, 0); cycle(1, 0);
        end
        for (int i = 0; i < 6; i++)  cycle(0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0);
        chk("t4_pulses", 32'(pulses5), 32'd2);

        // Reset while a deferred 10 is pending; lines stay high afterwards.
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1, 1);
            seen = m_pend;
        end
        chk("t5_pending_reached", 32'(seen), 32'd1);
        pulses5 = 0; pulses10 = 0;
        do_reset();
        chk("t5_inp_cleared", 32'(inp), 32'd0);
        for (int i = 0; i < 14; i++) cycle(1, 1);
        chk("t5_repress_p5",  32'(pulses5), 32'd1);
        chk("t5_repress_p10", 32'(pulses10), 32'd1);
        for (int i = 0; i < 12; i++) cycle(0, 0);

        // Randomised presses, bounces and occasional resets.
        l5 = 0; l10 = 0; h5 = 1; h10 = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--h5 == 0)  begin l5  = ~l5;  h5  = int'($urandom_range(1, 9)); end
            if (--h10 == 0) begin l10 = ~l10; h10 = int'($urandom_range(1, 9)); end
            n = int'($urandom_range(0, 399));
            if (n == 0) do_reset();
            else        cycle(l5, l10);
        end
        for (int i = 0; i < 12; i++) cycle(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
